zmips_regfile_mp: RTL and testbench
===================================

ZMIPS_REGFILE_MP -- requirements
Module: zmips_regfile_mp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the address space size: DEPTH-2 storage registers plus 2 PC aliases; legal values are 4..256 and powers of two.
REQ-003 The block SHALL have parameter NRD, default 2, meaning the number of read ports (1..8).
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning that when 1, address 0 is hardwired to zero.
REQ-005 AW SHALL equal clog2(DEPTH) and SHALL be derived, not user-set.
REQ-006 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port rd_addr SHALL be an input, NRD*AW bits: read addresses, port k at bits [k*AW +: AW].
REQ-009 Port rd_data SHALL be an output, NRD*WIDTH bits: read data, port k at bits [k*WIDTH +: WIDTH].
REQ-010 Port wr SHALL be an input, 1 bit: write enable.
REQ-011 Port wr_addr SHALL be an input, AW bits: write address.
REQ-012 Port wr_data SHALL be an input, WIDTH bits: write data.
REQ-013 Port pc_val SHALL be an input, WIDTH bits: live PC value.
REQ-014 Port pc_wr SHALL be an input, 1 bit: capture pc_val into the saved-PC register.
REQ-015 Port pc_q SHALL be an output, WIDTH bits: saved-PC register.
REQ-016 Port clr_req SHALL be an input, 1 bit: request a full storage clear.
REQ-017 Port busy SHALL be an output, 1 bit: clear sequence in progress.

Function
REQ-018 Storage addresses SHALL be 0..DEPTH-3; address DEPTH-2 SHALL read pc_val combinationally; address DEPTH-1 SHALL read pc_q.
REQ-019 Reads SHALL be combinational with zero-cycle latency, and all NRD ports SHALL be independent.
REQ-020 A write (wr=1, busy=0, storage address, and not address 0 when ZERO_REG=1) SHALL update storage on the rising clk edge.
REQ-021 A write to DEPTH-2 or DEPTH-1 SHALL be discarded.
REQ-022 Write-first bypass: when a write is accepted in the current cycle and wr_addr equals rd_addr[k], rd_data[k] SHALL equal wr_data in that same cycle.
REQ-023 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of any write or bypass.
REQ-024 pc_q SHALL load pc_val on the clk edge when pc_wr=1, independent of busy and wr.
REQ-025 The FSM SHALL have two states, IDLE and CLEAR, plus a clear counter cnt of AW bits.
REQ-026 IDLE->CLEAR SHALL occur when clr_req=1 at a clk edge, with cnt loaded to 0.
REQ-027 In CLEAR, each edge SHALL zero storage[cnt] and increment cnt; when cnt=DEPTH-3, after that zeroing the FSM SHALL move to IDLE; the sequence therefore lasts exactly DEPTH-2 cycles.
REQ-028 busy SHALL be 1 exactly while the state is CLEAR, as a registered output.
REQ-029 While busy=1, writes SHALL be ignored (no storage update, no bypass), and storage-address reads SHALL return 0.
REQ-030 clr_req while busy=1 SHALL be ignored, with no restart and no extension.
REQ-031 When clr_req=1 and wr=1 coincide in IDLE, the write SHALL be discarded and the clear SHALL start.
REQ-032 cnt SHALL never wrap past DEPTH-3.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for clk, set state=CLEAR, cnt=0, pc_q=0, and busy=1.
REQ-034 Storage SHALL be zeroed by the CLEAR sequence following reset release, not by rst itself; rd_data SHALL read 0 for storage addresses while busy=1.
REQ-035 rst asserted mid-CLEAR SHALL restart the sequence from cnt=0.
REQ-036 rst asserted mid-write SHALL cause that write to be lost.

Verification
REQ-037 Reset, DEPTH=32: after rst release, busy SHALL stay 1 for exactly 30 edges and then go to 0; every address 0..29 SHALL read 0 and pc_q SHALL read 0.
REQ-038 Bypass: write 0xDEADBEEF to r5 while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle, and the value SHALL persist after the edge.
REQ-039 Zero register: write 0x1234 to r0 -> r0 SHALL read 0; with ZERO_REG=0, r0 SHALL read 0x1234.
REQ-040 PC aliases: pc_val=0x400, pc_wr=1 for one edge, then pc_val=0x404 -> addr 30 SHALL read 0x404 and addr 31 SHALL read 0x400; a write to 30 or 31 SHALL have no effect.
REQ-041 Clear: fill r1..r29, then pulse clr_req -> writes are ignored and clr_req pulses are ignored during busy; after 30 cycles all registers SHALL read 0.
REQ-042 Parametrised run with WIDTH=16, DEPTH=8, NRD=4: busy SHALL last 6 cycles, and 4 simultaneous reads of distinct registers SHALL return the correct values.

Source files
------------

// File: rtl/zmips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : zmips_regfile_mp
// Purpose  : Multi-read-port register file with two PC alias addresses,
//            write-first bypass and a sequential clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module zmips_regfile_mp #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   input  logic                 wr,
   input  logic [AW-1:0]        wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [WIDTH-1:0]     pc_val,
   input  logic                 pc_wr,
   output logic [WIDTH-1:0]     pc_q,
   input  logic                 clr_req,
   output logic                 busy
);

   localparam logic [AW-1:0] c_LAST_REG = AW'(DEPTH - 3);
   localparam logic [AW-1:0] c_PC_LIVE  = AW'(DEPTH - 2);
   localparam logic [AW-1:0] c_PC_SAVED = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cnt_nxt;
   logic             w_clr_we;
   logic             w_wr_acc;
   logic [WIDTH-1:0] r_pc_q;
   logic [WIDTH-1:0] r_mem [DEPTH-2];

   // Clear engine: state and counter reset asynchronously into CLEAR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clr_req) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         S_CLEAR: begin
            w_clr_we = 1'b1;
            if (r_cnt == c_LAST_REG) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy = (r_state == S_CLEAR);

   // A clear request in the same cycle wins over a user write
   assign w_wr_acc = wr && (r_state == S_IDLE) && !clr_req &&
                     (wr_addr <= c_LAST_REG) &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_q <= '0;
      end else if (pc_wr) begin
         r_pc_q <= pc_val;
      end
   end

   assign pc_q = r_pc_q;

   generate
      for (genvar k = 0; k < NRD; k++) begin : g_rd
         logic [AW-1:0]    w_addr;
         logic [WIDTH-1:0] w_data;

         assign w_addr = rd_addr[k*AW +: AW];

         // Priority: zero register, PC aliases, clear blanking, bypass, array
         always_comb begin
            w_data = '0;
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
               w_data = '0;
            end else if (w_addr == c_PC_LIVE) begin
               w_data = pc_val;
            end else if (w_addr == c_PC_SAVED) begin
               w_data = r_pc_q;
            end else if (r_state == S_CLEAR) begin
               w_data = '0;
            end else if (w_wr_acc && (wr_addr == w_addr)) begin
               w_data = wr_data;
            end else begin
               w_data = r_mem[w_addr];
            end
         end

         assign rd_data[k*WIDTH +: WIDTH] = w_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_zmips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_zmips_regfile_mp
// Purpose  : Directed self-checking bench for zmips_regfile_mp (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zmips_regfile_mp;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // u0 (default) and u1 (ZERO_REG=0, one read port) share write/pc/clear inputs
   logic [9:0]  rd_addr0;
   logic [63:0] rd_data0;
   logic [4:0]  rd_addr1;
   logic [31:0] rd_data1;
   logic        wr, pc_wr, clr_req;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data, pc_val, pc_q0, pc_q1;
   logic        busy0, busy1;

   logic [11:0] rd_addr2;
   logic [63:0] rd_data2;
   logic        wr2, pc_wr2, clr2;
   logic [2:0]  wr_addr2;
   logic [15:0] wr_data2, pc_val2, pc_q2;
   logic        busy2;

   int checks = 0;
   int errors = 0;
   int n0, n2, n;

   zmips_regfile_mp u0 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr0), .rd_data(rd_data0),
      .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_val(pc_val),
      .pc_wr(pc_wr), .pc_q(pc_q0), .clr_req(clr_req), .busy(busy0)
   );

   zmips_regfile_mp #(.NRD(1), .ZERO_REG(0)) u1 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_val(pc_val),
      .pc_wr(pc_wr), .pc_q(pc_q1), .clr_req(clr_req), .busy(busy1)
   );

   zmips_regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(4)) u2 (
      .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .wr(wr2), .wr_addr(wr_addr2), .wr_data(wr_data2), .pc_val(pc_val2),
      .pc_wr(pc_wr2), .pc_q(pc_q2), .clr_req(clr2), .busy(busy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until busy is first seen low; 0 means it never dropped
   task automatic wait_idle(output int c0, output int c2);
      c0 = 0;
      c2 = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (c0 == 0 && !busy0) c0 = k;
         if (c2 == 0 && !busy2) c2 = k;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_addr0 = '0; rd_addr1 = '0; wr = 0; pc_wr = 0; clr_req = 0;
      wr_addr = '0; wr_data = '0; pc_val = '0;
      rd_addr2 = '0; wr2 = 0; pc_wr2 = 0; clr2 = 0;
      wr_addr2 = '0; wr_data2 = '0; pc_val2 = '0;

      // Reset acts before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_busy0", busy0, 1);
      chk("rst_busy1", busy1, 1);
      chk("rst_busy2", busy2, 1);
      chk("rst_pc_q0", pc_q0, 0);
      chk("rst_pc_q1", pc_q1, 0);
      tick();
      tick();
      rst = 1'b0;
      wait_idle(n0, n2);
      chk("rst_clear_len32", n0, 30);
      chk("rst_clear_len8", n2, 6);
      for (int i = 0; i < 30; i++) begin
         rd_addr0[4:0] = 5'(i);
         #1;
         chk("rst_read_zero", rd_data0[31:0], 0);
      end
      rd_addr0[4:0] = 5'd31;
      #1;
      chk("rst_pc_alias", rd_data0[31:0], 0);

      // Bypass and persistence
      tick();
      wr = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      rd_addr0 = {5'd6, 5'd5}; rd_addr1 = 5'd5;
      #1;
      chk("bypass_p0", rd_data0[31:0], 32'hDEADBEEF);
      chk("bypass_other", rd_data0[63:32], 0);
      chk("bypass_u1", rd_data1, 32'hDEADBEEF);
      tick();
      wr = 0;
      #1;
      chk("bypass_persist", rd_data0[31:0], 32'hDEADBEEF);

      // Zero register with and without ZERO_REG
      tick();
      wr = 1; wr_addr = 5'd0; wr_data = 32'h1234;
      rd_addr0 = {5'd0, 5'd0}; rd_addr1 = 5'd0;
      #1;
      chk("zero_byp", rd_data0[31:0], 0);
      chk("nozero_byp", rd_data1, 32'h1234);
      tick();
      wr = 0;
      #1;
      chk("zero_reg", rd_data0[31:0], 0);
      chk("nozero_reg", rd_data1, 32'h1234);

      // PC aliases
      tick();
      pc_val = 32'h400; pc_wr = 1;
      tick();
      pc_wr = 0; pc_val = 32'h404;
      rd_addr0 = {5'd31, 5'd30};
      #1;
      chk("pc_live", rd_data0[31:0], 32'h404);
      chk("pc_saved", rd_data0[63:32], 32'h400);
      chk("pc_q", pc_q0, 32'h400);
      wr = 1; wr_addr = 5'd30; wr_data = 32'hBAD0;
      #1;
      chk("pc_live_wr", rd_data0[31:0], 32'h404);
      tick();
      wr_addr = 5'd31;
      #1;
      chk("pc_saved_wr", rd_data0[63:32], 32'h400);
      tick();
      wr = 0;
      #1;
      chk("pc_live_after", rd_data0[31:0], 32'h404);
      chk("pc_saved_after", rd_data0[63:32], 32'h400);

      // Fill r1..r29
      for (int i = 1; i < 30; i++) begin
         tick();
         wr = 1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      end
      tick();
      wr = 0;
      rd_addr0 = {5'd29, 5'd7};
      #1;
      chk("fill_r7", rd_data0[31:0], 32'h107);
      chk("fill_r29", rd_data0[63:32], 32'h11D);

      // Clear with a coincident write, then writes and clr pulses during busy
      tick();
      clr_req = 1; wr = 1; wr_addr = 5'd3; wr_data = 32'hAAAA;
      tick();
      clr_req = 0;
      wr = 1; wr_addr = 5'd2; wr_data = 32'hFFFF;
      rd_addr0 = {5'd2, 5'd7};
      pc_val = 32'h500; pc_wr = 1;
      #1;
      chk("clr_busy", busy0, 1);
      chk("clr_busy_read", rd_data0[31:0], 0);
      chk("clr_busy_byp", rd_data0[63:32], 0);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1) begin
            wr = 0; pc_wr = 0;
         end
         if (k == 10) clr_req = 1;
         if (k == 11) clr_req = 0;
         if (n == 0 && !busy0) n = k;
      end
      chk("clr_len", n, 30);
      chk("clr_idle", busy0, 0);
      chk("clr_pc_q", pc_q0, 32'h500);
      for (int i = 1; i < 30; i++) begin
         rd_addr0[4:0] = 5'(i);
         #1;
         chk("clr_read_zero", rd_data0[31:0], 0);
      end
      rd_addr1 = 5'd0;
      #1;
      chk("clr_u1_r0", rd_data1, 0);

      // Small configuration: four simultaneous reads
      for (int i = 1; i < 6; i++) begin
         tick();
         wr2 = 1; wr_addr2 = 3'(i); wr_data2 = 16'(i * 16'h1111);
      end
      tick();
      wr2 = 0; pc_val2 = 16'hABCD;
      rd_addr2 = {3'd5, 3'd4, 3'd3, 3'd1};
      #1;
      chk("mp_p0", rd_data2[15:0], 16'h1111);
      chk("mp_p1", rd_data2[31:16], 16'h3333);
      chk("mp_p2", rd_data2[47:32], 16'h4444);
      chk("mp_p3", rd_data2[63:48], 16'h5555);
      rd_addr2 = {3'd7, 3'd6, 3'd2, 3'd5};
      #1;
      chk("mp_r5", rd_data2[15:0], 16'h5555);
      chk("mp_r2", rd_data2[31:16], 16'h2222);
      chk("mp_pc_live", rd_data2[47:32], 16'hABCD);
      chk("mp_pc_saved", rd_data2[63:48], 0);

      // Reset mid-write and mid-clear restarts the sequence
      tick();
      wr = 1; wr_addr = 5'd9; wr_data = 32'h9999;
      tick();
      wr_addr = 5'd10; wr_data = 32'h7777;
      #2 rst = 1;
      #1;
      chk("rst_async_busy", busy0, 1);
      chk("rst_async_pc", pc_q0, 0);
      wr = 0;
      tick();
      rst = 0;
      for (int k = 0; k < 10; k++) tick();
      rst = 1;
      tick();
      rst = 0;
      wait_idle(n0, n2);
      chk("rst_restart_len32", n0, 30);
      chk("rst_restart_len8", n2, 6);
      rd_addr0 = {5'd10, 5'd9};
      #1;
      chk("rst_r9", rd_data0[31:0], 0);
      chk("rst_r10", rd_data0[63:32], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
